config_loader: RTL and testbench
================================

CONFIG_LOADER -- requirements
Module: config_loader

Interface
REQ-001 The block SHALL have parameter NUM_WORDS, default 1 (minimum 1): the chain length is 32*NUM_WORDS bits, i.e. one 32-bit word per switch-box module in the chain.
REQ-002 The block SHALL have port prog_clk, input, 1 bit: the single clock; every register is clocked on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: begins an operation when sampled high in IDLE.
REQ-005 The block SHALL have port mode, input, 1 bit: 0 = LOAD, 1 = VERIFY; sampled only with an accepted start.
REQ-006 The block SHALL have port word_data, input, 32 bits: configuration word (LOAD) or expected word (VERIFY).
REQ-007 The block SHALL have port word_valid, input, 1 bit: word_data is valid.
REQ-008 The block SHALL have port word_ready, output, 1 bit: the loader accepts word_data.
REQ-009 The block SHALL have port chain_din, output, 1 bit: drives prog_in of the first chain module.
REQ-010 The block SHALL have port chain_en, output, 1 bit: drives prog_en of all chain modules.
REQ-011 The block SHALL have port chain_dout, input, 1 bit: prog_out of the last chain module.
REQ-012 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-013 The block SHALL have port done, output, 1 bit: one-cycle pulse at the end of an operation.
REQ-014 The block SHALL have port err, output, 1 bit: sticky VERIFY mismatch flag.
REQ-015 The block SHALL have port mismatch_cnt, output, 8 bits: count of mismatched bits, saturating at 255.

Function
REQ-016 The block SHALL implement the states IDLE, FETCH, SHIFT and DONE.
REQ-017 IDLE: start=1 SHALL latch mode, clear err and mismatch_cnt, clear the word counter, and go to FETCH on the next edge; start in any other state SHALL be ignored.
REQ-018 FETCH: word_ready SHALL be 1, chain_en 0 and the chain held; a transfer occurs on the edge where word_valid and word_ready are both 1, loads the 32-bit shift buffer, and moves to SHIFT.
REQ-019 word_ready SHALL be 0 outside FETCH; word_valid outside FETCH SHALL be ignored.
REQ-020 SHIFT: chain_en SHALL be 1 for exactly 32 consecutive cycles, presenting buffer bits LSB first (bit 0 on the first cycle).
REQ-021 After the 32nd SHIFT cycle the block SHALL go to FETCH if fewer than NUM_WORDS words have been shifted, otherwise to DONE; a one-cycle chain_en gap per word is permitted.
REQ-022 Word order SHALL be: the first accepted word ends in the module furthest from chain_din (the last module), and word bit k ends in chain bit k.
REQ-023 LOAD: chain_din SHALL be the registered current buffer bit.
REQ-024 VERIFY: chain_din SHALL be combinationally equal to chain_dout (recirculation), so the chain contents are unchanged after 32*NUM_WORDS shifts.
REQ-025 VERIFY: on each SHIFT edge, chain_dout SHALL be compared with the current expected bit; on mismatch err is set to 1 and mismatch_cnt increments, saturating at 255.
REQ-026 LOAD SHALL never modify err or mismatch_cnt after the start clear.
REQ-027 DONE: done SHALL be 1 for one cycle, busy 1, then IDLE; err and mismatch_cnt SHALL hold until the next accepted start.
REQ-028 Total chain_en-high cycles per operation SHALL equal exactly 32*NUM_WORDS.

Reset
REQ-029 rst=0 SHALL immediately force IDLE and set word_ready=0, chain_en=0, chain_din=0, busy=0, done=0, err=0, mismatch_cnt=0, and clear the buffer and counters, including mid-SHIFT; a partially shifted chain is left as-is.
REQ-030 After rst returns to 1, the first accepted start SHALL behave as a fresh operation.

Verification
REQ-031 NUM_WORDS=1, LOAD 0xA5A50F0F into one switch-box model -> shift_reg = 0xA5A50F0F at done, chain_en high exactly 32 cycles, err=0.
REQ-032 Then VERIFY with 0xA5A50F0F -> err=0, mismatch_cnt=0, shift_reg still 0xA5A50F0F; VERIFY with 0xA5A50F0E -> err=1, mismatch_cnt=1.
REQ-033 NUM_WORDS=2, LOAD 0x11111111 then 0x22222222 -> last module = 0x11111111, first module = 0x22222222, 64 chain_en cycles, one done pulse.
REQ-034 word_valid held low 5 cycles in FETCH -> chain_en=0 throughout the stall, final contents identical to REQ-031.
REQ-035 rst asserted after 10 SHIFT cycles -> all outputs at reset values in the same cycle; a new LOAD of 0xFFFFFFFF then yields shift_reg = 0xFFFFFFFF.
REQ-036 start pulsed during SHIFT -> ignored, bit count and mode unchanged; VERIFY of 0x00000000 against chain 0xFFFFFFFF -> mismatch_cnt=32, err=1.

Source files
------------

// File: rtl/config_loader.sv
// Serial loader/verifier for a chain of 32-bit switch-box configuration registers.
// Latency: 1 cycle start->FETCH, then per word 1 fetch cycle + 32 shift cycles, then a 1-cycle done.
// Backpressure: word_ready only in FETCH; a stalled word_valid parks the FSM with chain_en low.
module config_loader #(
  parameter int NUM_WORDS = 1
) (
  input  logic        prog_clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mode,
  input  logic [31:0] word_data,
  input  logic        word_valid,
  output logic        word_ready,
  output logic        chain_din,
  output logic        chain_en,
  input  logic        chain_dout,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  mismatch_cnt
);

  localparam int WCW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [WCW-1:0] LAST_WORD = WCW'(NUM_WORDS - 1);

  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;

  state_t         state, state_nxt;
  logic           mode_q;
  logic [31:0]    buf_q;
  logic [4:0]     bit_cnt;
  logic [WCW-1:0] word_cnt;
  logic           start_acc;
  logic           word_acc;
  logic           last_bit;
  logic           bit_miss;

  assign last_bit = (bit_cnt == 5'd31);
  assign bit_miss = mode_q && (chain_dout != buf_q[0]);

  // VERIFY recirculates the chain so its contents survive the pass.
  assign chain_din = mode_q ? chain_dout : buf_q[0];

  always_ff @(posedge prog_clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    word_ready = 1'b0;
    chain_en   = 1'b0;
    busy       = 1'b1;
    done       = 1'b0;
    start_acc  = 1'b0;
    word_acc   = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          start_acc = 1'b1;
          state_nxt = FETCH;
        end
      end
      FETCH: begin
        word_ready = 1'b1;
        if (word_valid) begin
          word_acc  = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        chain_en = 1'b1;
        if (last_bit) state_nxt = (word_cnt == LAST_WORD) ? DONE : FETCH;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge prog_clk or negedge rst) begin
    if (!rst) begin
      mode_q       <= 1'b0;
      buf_q        <= '0;
      bit_cnt      <= '0;
      word_cnt     <= '0;
      err          <= 1'b0;
      mismatch_cnt <= '0;
    end else begin
      if (start_acc) begin
        mode_q       <= mode;
        word_cnt     <= '0;
        err          <= 1'b0;
        mismatch_cnt <= '0;
      end
      if (word_acc) begin
        buf_q   <= word_data;
        bit_cnt <= '0;
      end
      if (chain_en) begin
        buf_q   <= {1'b0, buf_q[31:1]};
        bit_cnt <= bit_cnt + 5'd1;
        if (last_bit && (word_cnt != LAST_WORD)) word_cnt <= word_cnt + WCW'(1);
        // Only VERIFY can raise bit_miss, so LOAD never touches the error state.
        if (bit_miss) begin
          err <= 1'b1;
          if (mismatch_cnt != 8'hFF) mismatch_cnt <= mismatch_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_config_loader.sv
// Bench for config_loader: 1-, 2- and 8-word chains modelled as shift registers.
// Table vectors and a scoreboard queue popped on each done pulse of the 1-word instance.
// Hand sequences cover stalls, mid-shift reset, ignored start, word order and saturation.
module tb_config_loader;

  logic prog_clk = 1'b0;
  logic rst = 1'b1;
  always #5 prog_clk = ~prog_clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // ---------------- instance 1: NUM_WORDS=1
  logic st1 = 0, md1 = 0, wv1 = 0, wr1, din1, en1, dout1, busy1, done1, err1;
  logic [31:0] wd1 = '0;
  logic [7:0]  cnt1;
  logic [31:0] v1 = '0;
  always @(posedge prog_clk) if (en1) v1 <= {din1, v1[31:1]};
  assign dout1 = v1[0];

  config_loader #(.NUM_WORDS(1)) dut1 (
    .prog_clk(prog_clk), .rst(rst), .start(st1), .mode(md1), .word_data(wd1),
    .word_valid(wv1), .word_ready(wr1), .chain_din(din1), .chain_en(en1),
    .chain_dout(dout1), .busy(busy1), .done(done1), .err(err1), .mismatch_cnt(cnt1));

  // ---------------- instance 2: NUM_WORDS=2
  logic st2 = 0, md2 = 0, wv2 = 0, wr2, din2, en2, dout2, busy2, done2, err2;
  logic [31:0] wd2 = '0;
  logic [7:0]  cnt2;
  logic [63:0] v2 = '0;
  always @(posedge prog_clk) if (en2) v2 <= {din2, v2[63:1]};
  assign dout2 = v2[0];

  config_loader #(.NUM_WORDS(2)) dut2 (
    .prog_clk(prog_clk), .rst(rst), .start(st2), .mode(md2), .word_data(wd2),
    .word_valid(wv2), .word_ready(wr2), .chain_din(din2), .chain_en(en2),
    .chain_dout(dout2), .busy(busy2), .done(done2), .err(err2), .mismatch_cnt(cnt2));

  // ---------------- instance 3: NUM_WORDS=8
  logic st3 = 0, md3 = 0, wv3 = 0, wr3, din3, en3, dout3, busy3, done3, err3;
  logic [31:0]  wd3 = '0;
  logic [7:0]   cnt3;
  logic [255:0] v3 = '0;
  always @(posedge prog_clk) if (en3) v3 <= {din3, v3[255:1]};
  assign dout3 = v3[0];

  config_loader #(.NUM_WORDS(8)) dut3 (
    .prog_clk(prog_clk), .rst(rst), .start(st3), .mode(md3), .word_data(wd3),
    .word_valid(wv3), .word_ready(wr3), .chain_din(din3), .chain_en(en3),
    .chain_dout(dout3), .busy(busy3), .done(done3), .err(err3), .mismatch_cnt(cnt3));

  // ---------------- scoreboard for instance 1
  typedef struct {
    logic        err;
    logic [7:0]  cnt;
    logic [31:0] chain;
    int          en;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   en_cnt1 = 0;

  always @(negedge prog_clk) begin
    if (!rst) begin
      en_cnt1 = 0;
    end else begin
      if (en1) en_cnt1++;
      if (done1) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_done: got done=1 want no done");
        end else begin
          e = sb.pop_front();
          chk("op_err", err1, e.err);
          chk("op_mismatch_cnt", cnt1, e.cnt);
          chk("op_chain", v1, e.chain);
          chk("op_en_cycles", en_cnt1, e.en);
        end
        en_cnt1 = 0;
      end
    end
  end

  task automatic op1(input logic m, input logic [31:0] w, input int stall, input int poke,
                     input logic e_err, input logic [7:0] e_cnt, input logic [31:0] e_chain);
    int se;
    int k;
    sb.push_back('{err: e_err, cnt: e_cnt, chain: e_chain, en: 32});
    @(negedge prog_clk);
    st1 = 1'b1; md1 = m; wd1 = w; wv1 = 1'b0;
    @(negedge prog_clk);
    st1 = 1'b0;
    chk("fetch_ready", wr1, 1'b1);
    chk("fetch_busy", busy1, 1'b1);
    se = 0;
    for (int i = 0; i < stall; i++) begin
      if (en1) se++;
      @(negedge prog_clk);
    end
    if (stall > 0) chk("stall_chain_en", se, 0);
    wv1 = 1'b1;
    @(negedge prog_clk);
    wv1 = 1'b0;
    k = 0;
    while (!done1 && k < 100) begin
      st1 = (poke != 0) && (k == poke);
      if (st1) md1 = ~m;
      @(negedge prog_clk);
      k++;
    end
    st1 = 1'b0;
    md1 = m;
    chk("done_seen", done1, 1'b1);
    @(negedge prog_clk);
    chk("done_one_cycle", done1, 1'b0);
    chk("back_idle", busy1, 1'b0);
  endtask

  typedef struct {
    logic        mode;
    logic [31:0] word;
    int          stall;
    logic        e_err;
    logic [7:0]  e_cnt;
    logic [31:0] e_chain;
  } vec_t;

  vec_t vecs[8];
  logic [31:0] words2[2];
  int idx, en_n, dn_n, k;

  initial begin
    vecs[0] = '{mode: 1'b0, word: 32'hA5A50F0F, stall: 0, e_err: 1'b0, e_cnt: 8'd0,  e_chain: 32'hA5A50F0F};
    vecs[1] = '{mode: 1'b1, word: 32'hA5A50F0F, stall: 0, e_err: 1'b0, e_cnt: 8'd0,  e_chain: 32'hA5A50F0F};
    vecs[2] = '{mode: 1'b1, word: 32'hA5A50F0E, stall: 0, e_err: 1'b1, e_cnt: 8'd1,  e_chain: 32'hA5A50F0F};
    vecs[3] = '{mode: 1'b0, word: 32'h00000000, stall: 0, e_err: 1'b0, e_cnt: 8'd0,  e_chain: 32'h00000000};
    vecs[4] = '{mode: 1'b0, word: 32'hA5A50F0F, stall: 5, e_err: 1'b0, e_cnt: 8'd0,  e_chain: 32'hA5A50F0F};
    vecs[5] = '{mode: 1'b1, word: 32'h5A5AF0F0, stall: 0, e_err: 1'b1, e_cnt: 8'd32, e_chain: 32'hA5A50F0F};
    vecs[6] = '{mode: 1'b0, word: 32'h0000FFFF, stall: 2, e_err: 1'b0, e_cnt: 8'd0,  e_chain: 32'h0000FFFF};
    vecs[7] = '{mode: 1'b1, word: 32'h0000FFFF, stall: 0, e_err: 1'b0, e_cnt: 8'd0,  e_chain: 32'h0000FFFF};

    #2 rst = 1'b0;
    repeat (2) @(negedge prog_clk);
    chk("rst_word_ready", wr1, 1'b0);
    chk("rst_chain_en", en1, 1'b0);
    chk("rst_chain_din", din1, 1'b0);
    chk("rst_busy", busy1, 1'b0);
    chk("rst_done", done1, 1'b0);
    chk("rst_err", err1, 1'b0);
    chk("rst_mismatch_cnt", cnt1, 8'd0);
    chk("rst_busy_2", busy2, 1'b0);
    chk("rst_busy_3", busy3, 1'b0);
    rst = 1'b1;

    for (int i = 0; i < 8; i++)
      op1(vecs[i].mode, vecs[i].word, vecs[i].stall, 0, vecs[i].e_err, vecs[i].e_cnt, vecs[i].e_chain);

    // VERIFY zeros against 0x0000FFFF, reset after 10 shift cycles (10 mismatches so far)
    @(negedge prog_clk);
    st1 = 1'b1; md1 = 1'b1; wd1 = 32'h0;
    @(negedge prog_clk);
    st1 = 1'b0; wv1 = 1'b1;
    @(negedge prog_clk);
    wv1 = 1'b0;
    repeat (10) @(negedge prog_clk);
    chk("mid_shift_en", en1, 1'b1);
    chk("mid_shift_cnt", cnt1, 8'd10);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_word_ready", wr1, 1'b0);
    chk("async_rst_chain_en", en1, 1'b0);
    chk("async_rst_chain_din", din1, 1'b0);
    chk("async_rst_busy", busy1, 1'b0);
    chk("async_rst_done", done1, 1'b0);
    chk("async_rst_err", err1, 1'b0);
    chk("async_rst_mismatch_cnt", cnt1, 8'd0);
    repeat (2) @(negedge prog_clk);
    rst = 1'b1;
    md1 = 1'b0;

    op1(1'b0, 32'hFFFFFFFF, 0, 0, 1'b0, 8'd0, 32'hFFFFFFFF);
    // start pulsed mid-SHIFT with the opposite mode must be ignored
    op1(1'b1, 32'h00000000, 0, 5, 1'b1, 8'd32, 32'hFFFFFFFF);
    repeat (3) @(negedge prog_clk);
    chk("err_holds", err1, 1'b1);
    chk("cnt_holds", cnt1, 8'd32);

    // two-word LOAD: first word lands in the last module
    words2[0] = 32'h11111111;
    words2[1] = 32'h22222222;
    @(negedge prog_clk);
    st2 = 1'b1; md2 = 1'b0;
    @(negedge prog_clk);
    st2 = 1'b0;
    idx = 0; en_n = 0; dn_n = 0; k = 0;
    while (dn_n == 0 && k < 300) begin
      if (en2) en_n++;
      if (done2) dn_n++;
      wv2 = 1'b0;
      if (wr2 && idx < 2) begin
        wv2 = 1'b1;
        wd2 = words2[idx];
        idx++;
      end
      @(negedge prog_clk);
      k++;
    end
    wv2 = 1'b0;
    repeat (3) begin
      @(negedge prog_clk);
      if (done2) dn_n++;
    end
    chk("w2_done_pulses", dn_n, 1);
    chk("w2_en_cycles", en_n, 64);
    chk("w2_last_module", v2[31:0], 32'h11111111);
    chk("w2_first_module", v2[63:32], 32'h22222222);
    chk("w2_err", err2, 1'b0);

    // eight-word VERIFY of all ones against an all-zero chain: 256 misses saturate
    @(negedge prog_clk);
    st3 = 1'b1; md3 = 1'b1;
    @(negedge prog_clk);
    st3 = 1'b0;
    idx = 0; en_n = 0; dn_n = 0; k = 0;
    while (dn_n == 0 && k < 1000) begin
      if (en3) en_n++;
      if (done3) dn_n++;
      wv3 = 1'b0;
      if (wr3 && idx < 8) begin
        wv3 = 1'b1;
        wd3 = 32'hFFFFFFFF;
        idx++;
      end
      @(negedge prog_clk);
      k++;
    end
    wv3 = 1'b0;
    chk("w8_done_seen", dn_n, 1);
    chk("w8_en_cycles", en_n, 256);
    chk("w8_mismatch_sat", cnt3, 8'd255);
    chk("w8_err", err3, 1'b1);
    chk("w8_chain_unchanged", (v3 == '0), 1'b1);

    repeat (2) @(negedge prog_clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
